// File: rtl/cordic_sincos.sv
// Iterative CORDIC sine/cosine engine: one micro-rotation per enabled cycle,
// quadrant pre-rotation for full-circle input, out-of-range angles flagged.
module cordic_sincos #(
  parameter int WIDTH = 22,
  parameter int FRAC  = 18,
  parameter int ITER  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clk_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] angle,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] cos_out,
  output logic signed [WIDTH-1:0] sin_out,
  output logic                    range_err
);

  // Angle constants rounded to nearest in the FRAC-bit fixed-point format.
  localparam real    SCALE_R = real'(longint'(1) << FRAC);
  localparam longint PI_L    = longint'($floor(3.14159265358979323846 * SCALE_R + 0.5));
  localparam longint HPI_L   = longint'($floor(1.57079632679489661923 * SCALE_R + 0.5));
  localparam longint X0_L    = longint'($floor(0.6072529350 * SCALE_R + 0.5));

  localparam logic signed [WIDTH-1:0] PI_S  = WIDTH'(PI_L);
  localparam logic signed [WIDTH-1:0] HPI_S = WIDTH'(HPI_L);
  localparam logic signed [WIDTH-1:0] X0_S  = WIDTH'(X0_L);

  // Arctan table is held at 2^30 scale; rounding shift brings it down to FRAC.
  localparam int     SH  = 30 - FRAC;
  localparam longint RND = (longint'(1) << SH) >> 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // atan(2^-i) * 2^30 rounded; from i=10 upward the entry equals 2^(30-i).
  function automatic logic signed [WIDTH-1:0] atan_lut(input logic [4:0] idx);
    longint raw;
    case (idx)
      5'd0:    raw = 64'sd843314857;
      5'd1:    raw = 64'sd497837829;
      5'd2:    raw = 64'sd263043837;
      5'd3:    raw = 64'sd133525159;
      5'd4:    raw = 64'sd67021687;
      5'd5:    raw = 64'sd33543516;
      5'd6:    raw = 64'sd16775851;
      5'd7:    raw = 64'sd8388437;
      5'd8:    raw = 64'sd4194283;
      5'd9:    raw = 64'sd2097149;
      5'd31:   raw = '0;
      default: raw = longint'(1) << (5'd30 - idx);
    endcase
    return WIDTH'((raw + RND) >>> SH);
  endfunction

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] x_q, x_d;
  logic signed [WIDTH-1:0] y_q, y_d;
  logic signed [WIDTH-1:0] z_q, z_d;
  logic        [4:0]       i_q, i_d;
  logic                    neg_q, neg_d;
  logic signed [WIDTH-1:0] cos_q, cos_d;
  logic signed [WIDTH-1:0] sin_q, sin_d;
  logic                    err_q, err_d;

  logic signed [WIDTH-1:0] x_sh, y_sh, atan_i;
  logic signed [WIDTH-1:0] x_rot, y_rot, z_rot;

  // One micro-rotation step, direction chosen by the sign of the residual angle.
  always_comb begin
    x_sh   = x_q >>> i_q;
    y_sh   = y_q >>> i_q;
    atan_i = atan_lut(i_q);
    if (!z_q[WIDTH-1]) begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - atan_i;
    end else begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + atan_i;
    end
  end

  // Next-state and datapath load decisions for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    neg_d   = neg_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if ((angle > PI_S) || (angle < -PI_S)) begin
            err_d   = 1'b1;
            cos_d   = '0;
            sin_d   = '0;
            state_d = S_DONE;
          end else begin
            x_d     = X0_S;
            y_d     = '0;
            i_d     = '0;
            state_d = S_RUN;
            // Fold outer quadrants by pi and negate the result at the end.
            if (angle > HPI_S) begin
              z_d   = angle - PI_S;
              neg_d = 1'b1;
            end else if (angle < -HPI_S) begin
              z_d   = angle + PI_S;
              neg_d = 1'b1;
            end else begin
              z_d   = angle;
              neg_d = 1'b0;
            end
          end
        end
      end
      S_RUN: begin
        if (clk_en) begin
          x_d = x_rot;
          y_d = y_rot;
          z_d = z_rot;
          if (i_q == 5'(ITER - 1)) begin
            cos_d   = neg_q ? -x_rot : x_rot;
            sin_d   = neg_q ? -y_rot : y_rot;
            err_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            i_d = i_q + 5'd1;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      neg_q   <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      neg_q   <= neg_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign cos_out   = cos_q;
  assign sin_out   = sin_q;
  assign range_err = err_q;

endmodule

// File: tb/tb_cordic_sincos.sv
// Directed table-driven bench for cordic_sincos at default parameters.
module tb_cordic_sincos;

  localparam int WIDTH = 22;
  localparam int FRAC  = 18;
  localparam int ITER  = 16;
  localparam int TOL   = 8;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    clk_en;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] angle;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] cos_out;
  logic signed [WIDTH-1:0] sin_out;
  logic                    range_err;

  int checks = 0;
  int errors = 0;

  cordic_sincos #(.WIDTH(WIDTH), .FRAC(FRAC), .ITER(ITER)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_en   (clk_en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .angle    (angle),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .cos_out  (cos_out),
    .sin_out  (sin_out),
    .range_err(range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    ang;
    int    gaps;
    int    cos_e;
    int    sin_e;
    int    err_e;
    int    lat_e;
  } vec_t;

  vec_t vecs[$];

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    checks++;
    if ((act - exp > tol) || (exp - act > tol)) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic check_eq(input string name, input int act, input int exp);
    check_near(name, act, exp, 0);
  endtask

  // Accept one angle, let it run (clk_en low for the first 'gaps' RUN cycles),
  // return outputs seen on the first out_valid cycle, then release DONE.
  task automatic do_op(input string name, input int ang, input int gaps,
                       output int c, output int s, output int e, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({name, "_in_ready"}, int'(in_ready), 1);
    angle    = WIDTH'(ang);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    angle    = 22'sh0AAAAA;
    lat = 0;
    while (!out_valid && lat < 200) begin
      clk_en = (lat < gaps) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    clk_en = 1'b1;
    check_eq({name, "_out_valid"}, int'(out_valid), 1);
    c = int'(cos_out);
    s = int'(sin_out);
    e = int'(range_err);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({name, "_released"}, int'(out_valid), 0);
  endtask

  initial begin
    int c, s, e, lat, seen;

    vecs.push_back('{"zero",      0,       0,  262144,       0, 0, 16});
    vecs.push_back('{"pi6",       137258,  0,  227023,  131072, 0, 16});
    vecs.push_back('{"pi3",       274517,  0,  131072,  227023, 0, 16});
    vecs.push_back('{"pi",        823550,  0, -262144,       0, 0, 16});
    vecs.push_back('{"neg_pi",   -823550,  0, -262144,       0, 0, 16});
    vecs.push_back('{"neg_hpi",  -411775,  0,       0, -262144, 0, 16});
    vecs.push_back('{"hpi",       411775,  0,       0,  262144, 0, 16});
    vecs.push_back('{"5pi6",      686291,  0, -227023,  131072, 0, 16});
    vecs.push_back('{"neg_2pi3", -549034,  0, -131072, -227023, 0, 16});
    vecs.push_back('{"oor_900k",  900000,  0,       0,       0, 1, 0});
    vecs.push_back('{"pi6_after", 137258,  0,  227023,  131072, 0, 16});
    vecs.push_back('{"oor_pi_p1", 823551,  0,       0,       0, 1, 0});
    vecs.push_back('{"oor_npi_m1",-823551, 0,       0,       0, 1, 0});
    vecs.push_back('{"pi6_gap3",  137258,  3,  227023,  131072, 0, 19});

    reset_n   = 1'b0;
    clk_en    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    angle     = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_cos", int'(cos_out), 0);
    check_eq("rst_sin", int'(sin_out), 0);
    check_eq("rst_err", int'(range_err), 0);
    check_eq("rst_in_ready", int'(in_ready), 1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[k]) begin
      do_op(vecs[k].name, vecs[k].ang, vecs[k].gaps, c, s, e, lat);
      check_near({vecs[k].name, "_cos"}, c, vecs[k].cos_e, vecs[k].err_e != 0 ? 0 : TOL);
      check_near({vecs[k].name, "_sin"}, s, vecs[k].sin_e, vecs[k].err_e != 0 ? 0 : TOL);
      check_eq({vecs[k].name, "_err"}, e, vecs[k].err_e);
      check_eq({vecs[k].name, "_latency"}, lat, vecs[k].lat_e);
    end

    // Backpressure: error result held in DONE while in_valid pulses.
    angle    = WIDTH'(900000);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp_first_valid", int'(out_valid), 1);
    for (int k = 0; k < 10; k++) begin
      in_valid = (k % 2 == 0);
      angle    = WIDTH'(137258);
      @(posedge clk); #1;
      check_eq("bp_out_valid", int'(out_valid), 1);
      check_eq("bp_in_ready", int'(in_ready), 0);
      check_eq("bp_cos", int'(cos_out), 0);
      check_eq("bp_sin", int'(sin_out), 0);
      check_eq("bp_err", int'(range_err), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("bp_release_in_ready", int'(in_ready), 1);
    check_eq("bp_release_out_valid", int'(out_valid), 0);
    do_op("bp_next", 137258, 0, c, s, e, lat);
    check_near("bp_next_cos", c, 227023, TOL);
    check_near("bp_next_sin", s, 131072, TOL);
    check_eq("bp_next_err", e, 0);
    check_eq("bp_next_latency", lat, 16);

    // Reset in the middle of RUN discards the operation.
    angle    = WIDTH'(274517);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("mid_in_ready_busy", int'(in_ready), 0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("mid_rst_out_valid", int'(out_valid), 0);
    check_eq("mid_rst_cos", int'(cos_out), 0);
    check_eq("mid_rst_sin", int'(sin_out), 0);
    check_eq("mid_rst_err", int'(range_err), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    check_eq("mid_rst_no_stale", seen, 0);

    do_op("post_rst", 0, 0, c, s, e, lat);
    check_near("post_rst_cos", c, 262144, TOL);
    check_near("post_rst_sin", s, 0, TOL);
    check_eq("post_rst_latency", lat, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
